nibble_serial_add16: RTL and testbench

NIBBLE_SERIAL_ADD16 -- requirements
Module: nibble_serial_add16

---
 rtl/nibble_serial_add16.sv | 144 ++++++++++++++
 tb/tb_nibble_serial_add16.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nibble_serial_add16.sv
`default_nettype none
// ============================================================================
//  Module      : nibble_serial_add16
//  Description : 16-bit adder that reuses one 4-bit add stage across four
//                nibbles, one nibble per clock. The optional subtract mode is
//                enabled with macro NIBBLE_SERIAL_SUB_EN.
//  Revision    : 1.0 - initial release
// ============================================================================
module nibble_serial_add16 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        Cin,
`ifdef NIBBLE_SERIAL_SUB_EN
    input  logic        sub,
`endif
    output logic [15:0] S,
    output logic        Cout,
    output logic        ovfl,
    output logic        busy,
    output logic        done
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ADD  = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]  state_q, state_d;
    logic [1:0]  cnt_q, cnt_d;
    logic [15:0] a_q, b_q;
    logic        cin_q;
    logic        carry_q, carry_d;
    logic [15:0] s_q, s_d;
    logic        cout_q, cout_d;
    logic        ovfl_q, ovfl_d;

    logic        w_accept;
    logic [3:0]  w_lsb;
    logic [3:0]  w_a_nib;
    logic [3:0]  w_b_nib;
    logic        w_cin_nib;
    logic [4:0]  w_sum;
    logic        w_c15;
    logic [15:0] w_b_load;
    logic        w_cin_load;

    assign w_accept = start && ((state_q == IDLE) || (state_q == DONE));

    // Subtraction is folded into operand latching: B is stored inverted and
    // the carry-in forced to 1, so the datapath itself only ever adds.
`ifdef NIBBLE_SERIAL_SUB_EN
    assign w_b_load   = sub ? ~B : B;
    assign w_cin_load = sub ? 1'b1 : Cin;
`else
    assign w_b_load   = B;
    assign w_cin_load = Cin;
`endif

    // The single shared 4-bit add stage
    assign w_lsb     = {cnt_q, 2'b00};
    assign w_a_nib   = a_q[w_lsb +: 4];
    assign w_b_nib   = b_q[w_lsb +: 4];
    assign w_cin_nib = (cnt_q == 2'd0) ? cin_q : carry_q;
    assign w_sum     = {1'b0, w_a_nib} + {1'b0, w_b_nib} + {4'b0000, w_cin_nib};

    // Carry into bit 15 recovered from the sum bit of the top nibble
    assign w_c15 = w_a_nib[3] ^ w_b_nib[3] ^ w_sum[3];

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        s_d     = s_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        ovfl_d  = ovfl_q;

        case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            ADD: begin
                s_d[w_lsb +: 4] = w_sum[3:0];
                carry_d         = w_sum[4];
                cnt_d           = cnt_q + 2'd1;
                if (cnt_q == 2'd3) begin
                    cout_d  = w_sum[4];
                    ovfl_d  = w_c15 ^ w_sum[4];
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (w_accept) begin
            state_d = ADD;
            cnt_d   = 2'd0;
            s_d     = 16'h0000;
            carry_d = 1'b0;
            cout_d  = 1'b0;
            ovfl_d  = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= 2'd0;
            a_q     <= 16'h0000;
            b_q     <= 16'h0000;
            cin_q   <= 1'b0;
            carry_q <= 1'b0;
            s_q     <= 16'h0000;
            cout_q  <= 1'b0;
            ovfl_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            s_q     <= s_d;
            cout_q  <= cout_d;
            ovfl_q  <= ovfl_d;
            if (w_accept) begin
                a_q   <= A;
                b_q   <= w_b_load;
                cin_q <= w_cin_load;
            end
        end
    end

    assign S    = s_q;
    assign Cout = cout_q;
    assign ovfl = ovfl_q;
    assign busy = (state_q == ADD);
    assign done = (state_q == DONE);

endmodule
`default_nettype wire

// File: tb/tb_nibble_serial_add16.sv
`default_nettype none
// ============================================================================
//  Module      : tb_nibble_serial_add16
//  Description : Randomised self-checking bench for nibble_serial_add16,
//                including subtract mode when NIBBLE_SERIAL_SUB_EN is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_nibble_serial_add16;

    logic        clk;
    logic        rst;
    logic        start;
    logic [15:0] A;
    logic [15:0] B;
    logic        Cin;
    logic        sub;
    logic [15:0] S;
    logic        Cout;
    logic        ovfl;
    logic        busy;
    logic        done;

    int n_checks;
    int n_fail;

    nibble_serial_add16 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
`ifdef NIBBLE_SERIAL_SUB_EN
        .sub   (sub),
`endif
        .S     (S),
        .Cout  (Cout),
        .ovfl  (ovfl),
        .busy  (busy),
        .done  (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference: {ovfl, Cout, S} from whole-word integer arithmetic
    function automatic logic [17:0] model(input logic [15:0] a, input logic [15:0] b,
                                          input logic ci, input logic sb);
        int ua, ub, sa, sb_i, t, sres;
        logic [15:0] s;
        logic co, ov;
        ua   = int'(a);
        ub   = int'(b);
        sa   = int'($signed(a));
        sb_i = int'($signed(b));
        if (sb) begin
            t    = ua - ub;
            s    = t[15:0];
            co   = (ua >= ub);
            sres = sa - sb_i;
        end else begin
            t    = ua + ub + int'(ci);
            s    = t[15:0];
            co   = t[16];
            sres = sa + sb_i + int'(ci);
        end
        ov = (sres > 32767) || (sres < -32768);
        return {ov, co, s};
    endfunction

    // Launches one operation and waits for done; lat counts sampling points
    // after the accepting edge (5 = cycle after edge k+4), -1 on timeout.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b, input logic ci,
                         input logic sb, input bit b2b, input int inject_at,
                         output logic [15:0] s_o, output logic co_o, output logic ov_o,
                         output int lat, output bit busy_ok);
        int n;
        if (!b2b) @(negedge clk);
        A = a; B = b; Cin = ci; sub = sb; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); sub = 1'($urandom);
        lat = -1; busy_ok = 1'b1; n = 1;
        s_o = 16'h0; co_o = 1'b0; ov_o = 1'b0;
        while (n <= 20) begin
            if (done) begin
                lat = n; s_o = S; co_o = Cout; ov_o = ovfl;
                break;
            end
            if (!busy) busy_ok = 1'b0;
            if (n == inject_at) begin
                A = 16'($urandom); B = 16'($urandom); Cin = 1'($urandom); start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            n++;
        end
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; start = 1'b0; A = 16'hDEAD; B = 16'hBEEF; Cin = 1'b1; sub = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({S, Cout, ovfl, busy, done} !== 20'h0) begin
            n_fail++;
            $display("FAIL reset_state: got S=%h Cout=%b ovfl=%b busy=%b done=%b, want all 0",
                     S, Cout, ovfl, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_directed();
        logic [15:0] av[3], bv[3], s;
        logic        cv[3], co, ov;
        logic [17:0] exp_r[3];
        logic [17:0] want;
        int lat;
        bit bok;
        av[0] = 16'h1234; bv[0] = 16'h4321; cv[0] = 1'b0; exp_r[0] = {1'b0, 1'b0, 16'h5555};
        av[1] = 16'hFFFF; bv[1] = 16'h0000; cv[1] = 1'b1; exp_r[1] = {1'b0, 1'b1, 16'h0000};
        av[2] = 16'h7FFF; bv[2] = 16'h0001; cv[2] = 1'b0; exp_r[2] = {1'b1, 1'b0, 16'h8000};
        for (int i = 0; i < 3; i++) begin
            do_op(av[i], bv[i], cv[i], 1'b0, 1'b0, 0, s, co, ov, lat, bok);
            want = exp_r[i];
            n_checks++;
            if ({ov, co, s} !== want) begin
                n_fail++;
                $display("FAIL directed_%0d: got ovfl=%b Cout=%b S=%h, want %h", i, ov, co, s, want);
            end
            n_checks++;
            if (lat !== 5 || !bok) begin
                n_fail++;
                $display("FAIL latency_%0d: got %0d busy_ok=%b, want 5 busy_ok=1", i, lat, bok);
            end
            // Result must hold after done with no new start
            repeat (3) @(negedge clk);
            n_checks++;
            if ({ovfl, Cout, S, busy, done} !== {want, 2'b00}) begin
                n_fail++;
                $display("FAIL hold_%0d: got ovfl=%b Cout=%b S=%h busy=%b done=%b, want %h idle",
                         i, ovfl, Cout, S, busy, done, want);
            end
        end
    endtask

    task automatic test_random();
        logic [15:0] a, b, s;
        logic ci, co, ov;
        logic [17:0] want;
        int lat;
        bit bok;
        for (int i = 0; i < 20; i++) begin
            a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
            if (i == 0) begin a = 16'h8000; b = 16'h8000; ci = 1'b0; end
            want = model(a, b, ci, 1'b0);
            do_op(a, b, ci, 1'b0, 1'b0, 0, s, co, ov, lat, bok);
            n_checks++;
            if ({ov, co, s} !== want || lat !== 5) begin
                n_fail++;
                $display("FAIL random_%0d: A=%h B=%h Cin=%b got ovfl=%b Cout=%b S=%h lat=%0d, want %h lat=5",
                         i, a, b, ci, ov, co, s, lat, want);
            end
        end
    endtask

    task automatic test_ignore_start();
        logic [15:0] s;
        logic co, ov;
        int lat;
        bit bok;
        // Second start lands on edge k+2
        do_op(16'h0F0F, 16'h0101, 1'b1, 1'b0, 1'b0, 2, s, co, ov, lat, bok);
        n_checks++;
        if ({ov, co, s} !== model(16'h0F0F, 16'h0101, 1'b1, 1'b0) || lat !== 5 || !bok) begin
            n_fail++;
            $display("FAIL ignore_start: got ovfl=%b Cout=%b S=%h lat=%0d, want %h lat=5",
                     ov, co, s, lat, model(16'h0F0F, 16'h0101, 1'b1, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        logic [15:0] a, b, s;
        logic ci, co, ov;
        int lat;
        bit bok;
        do_op(16'hA5A5, 16'h5A5B, 1'b0, 1'b0, 1'b0, 0, s, co, ov, lat, bok);
        for (int i = 0; i < 4; i++) begin
            a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
            do_op(a, b, ci, 1'b0, 1'b1, 0, s, co, ov, lat, bok);
            n_checks++;
            if ({ov, co, s} !== model(a, b, ci, 1'b0) || lat !== 5 || !bok) begin
                n_fail++;
                $display("FAIL back_to_back_%0d: got ovfl=%b Cout=%b S=%h lat=%0d busy_ok=%b, want %h lat=5",
                         i, ov, co, s, lat, bok, model(a, b, ci, 1'b0));
            end
        end
    endtask

    task automatic test_reset_abort();
        bit saw_done;
        @(negedge clk);
        A = 16'h1111; B = 16'h2222; Cin = 1'b0; sub = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        // cnt==2 here; the reset edge must win over the in-flight add
        rst = 1'b1; start = 1'b1;
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        n_checks++;
        if (S !== 16'h0 || busy !== 1'b0 || done !== 1'b0 || Cout !== 1'b0 || ovfl !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_abort: got S=%h busy=%b done=%b Cout=%b ovfl=%b, want all 0",
                     S, busy, done, Cout, ovfl);
        end
        saw_done = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (done || busy) saw_done = 1'b1;
            @(negedge clk);
        end
        n_checks++;
        if (saw_done) begin
            n_fail++;
            $display("FAIL reset_no_done: got activity after abort, want none");
        end
    endtask

`ifdef NIBBLE_SERIAL_SUB_EN
    task automatic test_sub();
        logic [15:0] a, b, s;
        logic ci, co, ov;
        int lat;
        bit bok;
        do_op(16'h0005, 16'h0007, 1'b0, 1'b1, 1'b0, 0, s, co, ov, lat, bok);
        n_checks++;
        if (s !== 16'hFFFE || co !== 1'b0 || lat !== 5) begin
            n_fail++;
            $display("FAIL sub_5_7: got S=%h Cout=%b lat=%0d, want S=fffe Cout=0 lat=5", s, co, lat);
        end
        do_op(16'h8000, 16'h0001, 1'b0, 1'b1, 1'b0, 0, s, co, ov, lat, bok);
        n_checks++;
        if (s !== 16'h7FFF || ov !== 1'b1) begin
            n_fail++;
            $display("FAIL sub_8000_1: got S=%h ovfl=%b, want S=7fff ovfl=1", s, ov);
        end
        for (int i = 0; i < 10; i++) begin
            a = 16'($urandom); b = 16'($urandom); ci = 1'($urandom);
            do_op(a, b, ci, 1'b1, 1'b0, 0, s, co, ov, lat, bok);
            n_checks++;
            if ({ov, co, s} !== model(a, b, ci, 1'b1)) begin
                n_fail++;
                $display("FAIL sub_random_%0d: A=%h B=%h got %b %b %h, want %h",
                         i, a, b, ov, co, s, model(a, b, ci, 1'b1));
            end
        end
    endtask
`endif

    initial begin
        n_checks = 0;
        n_fail   = 0;
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_back_to_back();
        test_reset_abort();
`ifdef NIBBLE_SERIAL_SUB_EN
        test_sub();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
